ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 17 +
 rtl/ram_arbiter_ram.sv | 33 +++
 rtl/ram_arbiter.sv | 131 +++++++++++++
 tb/tb_ram_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
//   Shared sizing constants and the arbiter state enumeration.
//   ADDR_W  : RAM address width (8 words)
//   DATA_W  : RAM word width
//   NUM_REQ : number of requesters sharing the RAM
package ram_arbiter_pkg;

   localparam int ADDR_W  = 3;
   localparam int DATA_W  = 4;
   localparam int NUM_REQ = 2;

   typedef enum logic {
      ST_CLEAR,
      ST_SERVE
   } state_t;

endpackage

// File: rtl/ram_arbiter_ram.sv
// ram
//   Single-port RAM: synchronous write, combinational read.
//   i_clk        : clock, writes on rising edge
//   i_rst        : synchronous active-high reset; suppresses writes while high
//   i_write_en   : write strobe
//   i_addr       : word address, also drives the combinational read
//   i_write_data : data written when i_write_en is high
//   o_read_data  : mem[i_addr], combinational
module ram #(
   parameter int ADDR_W = ram_arbiter_pkg::ADDR_W,
   parameter int DATA_W = ram_arbiter_pkg::DATA_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_write_en,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_write_data,
   output logic [DATA_W-1:0] o_read_data
);

   logic [DATA_W-1:0] r_mem [2**ADDR_W];

   // NOTE: the storage array has no reset branch; the arbiter's clear sweep
   // zeroes it, which keeps the array mappable onto plain RAM cells.
   always_ff @(posedge i_clk) begin
      if (!i_rst && i_write_en) begin
         r_mem[i_addr] <= i_write_data;
      end
   end

   assign o_read_data = r_mem[i_addr];

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Two-requester round-robin arbiter in front of a shared RAM. After reset or
//   an i_clear pulse the RAM is swept to zero (CLEAR, 8 cycles); requests are
//   served only in SERVE.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_clear               : pulse, starts a clear sweep (SERVE only)
//   i_req, i_we           : per-requester request / write enable
//   i_addr0/1, i_wdata0/1 : per-requester address and write data
//   o_gnt                 : combinational one-hot grant
//   o_rvalid, o_rdata     : registered read response, one cycle after grant
//   o_ready               : high while in SERVE
module ram_arbiter #(
   parameter int ADDR_W = ram_arbiter_pkg::ADDR_W,
   parameter int DATA_W = ram_arbiter_pkg::DATA_W
) (
   input  logic                                i_clk,
   input  logic                                i_rst,
   input  logic                                i_clear,
   input  logic [ram_arbiter_pkg::NUM_REQ-1:0] i_req,
   input  logic [ram_arbiter_pkg::NUM_REQ-1:0] i_we,
   input  logic [ADDR_W-1:0]                   i_addr0,
   input  logic [ADDR_W-1:0]                   i_addr1,
   input  logic [DATA_W-1:0]                   i_wdata0,
   input  logic [DATA_W-1:0]                   i_wdata1,
   output logic [ram_arbiter_pkg::NUM_REQ-1:0] o_gnt,
   output logic [ram_arbiter_pkg::NUM_REQ-1:0] o_rvalid,
   output logic [DATA_W-1:0]                   o_rdata,
   output logic                                o_ready
);

   import ram_arbiter_pkg::*;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_clr_addr;
   logic                r_last;      // index of the most recently granted requester
   logic [NUM_REQ-1:0]  r_rvalid;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_ready;

   logic [NUM_REQ-1:0]  w_gnt;
   logic                w_win;       // index of this cycle's winner (valid when |w_gnt)
   logic                w_ram_we;
   logic [ADDR_W-1:0]   w_ram_addr;
   logic [DATA_W-1:0]   w_ram_wdata;
   logic [DATA_W-1:0]   w_ram_rdata;

   // Grant: clear and reset both take priority over any request.
   always_comb begin
      // NOTE: each combinational output is given a default first, so no path
      // through the block can leave it unassigned and infer a latch.
      w_gnt = '0;
      if (!i_rst && r_state == ST_SERVE && !i_clear) begin
         if (&i_req) begin
            w_gnt = r_last ? 2'b01 : 2'b10;
         end else begin
            w_gnt = i_req;
         end
      end
   end

   assign w_win = w_gnt[1];

   // RAM port mux: sweep counter during CLEAR, the winner's command otherwise.
   always_comb begin
      w_ram_we    = 1'b0;
      w_ram_addr  = r_clr_addr;
      w_ram_wdata = '0;
      if (r_state == ST_CLEAR) begin
         w_ram_we = 1'b1;
      end else if (|w_gnt) begin
         w_ram_we    = i_we[w_win];
         w_ram_addr  = w_win ? i_addr1  : i_addr0;
         w_ram_wdata = w_win ? i_wdata1 : i_wdata0;
      end
   end

   ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_write_en   (w_ram_we),
      .i_addr       (w_ram_addr),
      .i_write_data (w_ram_wdata),
      .o_read_data  (w_ram_rdata)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // here sees the pre-edge value of every other one.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_CLEAR;
         r_clr_addr <= '0;
         r_last     <= 1'b1;       // requester 0 wins the first tie
         r_rvalid   <= '0;
         r_rdata    <= '0;
         r_ready    <= 1'b0;
      end else begin
         r_rvalid <= '0;
         case (r_state)
            ST_CLEAR: begin
               r_clr_addr <= r_clr_addr + ADDR_W'(1);
               if (r_clr_addr == '1) begin
                  r_state <= ST_SERVE;
                  r_ready <= 1'b1;
               end
            end
            ST_SERVE: begin
               if (i_clear) begin
                  r_state    <= ST_CLEAR;
                  r_clr_addr <= '0;
                  r_ready    <= 1'b0;
               end else if (|w_gnt) begin
                  r_last <= w_win;
                  if (!i_we[w_win]) begin
                     r_rvalid <= w_gnt;
                     r_rdata  <= w_ram_rdata;
                  end
               end
            end
         endcase
      end
   end

   assign o_gnt    = w_gnt;
   assign o_rvalid = r_rvalid;
   assign o_rdata  = r_rdata;
   assign o_ready  = r_ready;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Self-checking bench for ram_arbiter. A behavioural model (word array,
//   remaining-clear-cycles count, last-winner index) predicts every output;
//   inputs change on the falling edge and outputs are compared just after.
module tb_ram_arbiter;

   logic       clk;
   logic       rst;
   logic       clr;
   logic [1:0] req;
   logic [1:0] we;
   logic [2:0] a0, a1;
   logic [3:0] d0, d1;
   logic [1:0] gnt;
   logic [1:0] rvalid;
   logic [3:0] rdata;
   logic       ready;

   ram_arbiter dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_clear  (clr),
      .i_req    (req),
      .i_we     (we),
      .i_addr0  (a0),
      .i_addr1  (a1),
      .i_wdata0 (d0),
      .i_wdata1 (d1),
      .o_gnt    (gnt),
      .o_rvalid (rvalid),
      .o_rdata  (rdata),
      .o_ready  (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [3:0] m_mem [8];
   logic       m_last;
   int         m_clear_left = 8;
   bit         m_known      = 1'b0;
   logic [1:0] e_gnt;
   logic [1:0] e_rvalid     = 2'b00;
   logic [3:0] e_rdata      = 4'h0;

   int n_pass  = 0;
   int n_total = 0;

   // Grant predicted from the arbitration rules and the current inputs.
   function automatic logic [1:0] model_grant();
      if (rst || clr || m_clear_left != 0 || req == 2'b00) return 2'b00;
      if (req == 2'b11) return (m_last == 1'b1) ? 2'b01 : 2'b10;
      return req;
   endfunction

   task automatic drive(input logic r, input logic c, input logic [1:0] rq, input logic [1:0] w,
                        input logic [2:0] ad0, input logic [3:0] wd0,
                        input logic [2:0] ad1, input logic [3:0] wd1);
      @(negedge clk);
      rst = r; clr = c; req = rq; we = w;
      a0 = ad0; d0 = wd0; a1 = ad1; d1 = wd1;
      #1;
      e_gnt = model_grant();
   endtask

   // Advance the model across the coming rising edge.
   task automatic commit();
      int         idx;
      logic [2:0] addr;
      if (rst) begin
         m_clear_left = 8; m_last = 1'b1; e_rvalid = 2'b00; e_rdata = 4'h0; m_known = 1'b1;
      end else if (m_clear_left != 0) begin
         m_mem[8 - m_clear_left] = 4'h0;
         m_clear_left--;
         e_rvalid = 2'b00;
      end else if (clr) begin
         m_clear_left = 8; e_rvalid = 2'b00;
      end else begin
         e_rvalid = 2'b00;
         if (e_gnt != 2'b00) begin
            idx  = e_gnt[1] ? 1 : 0;
            addr = (idx == 1) ? a1 : a0;
            if (we[idx]) m_mem[addr] = (idx == 1) ? d1 : d0;
            else begin
               e_rvalid = e_gnt;
               e_rdata  = m_mem[addr];
            end
            m_last = (idx == 1);
         end
      end
   endtask

   task automatic test_reset();
      drive(1, 0, 2'b00, 2'b00, 0, 0, 0, 0); commit();
      drive(1, 0, 2'b00, 2'b00, 0, 0, 0, 0);
      if (m_known) begin
         n_total++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready); else n_pass++;
         n_total++; if (rvalid !== 2'b00) $display("FAIL reset_rvalid: got %b want 00", rvalid); else n_pass++;
         n_total++; if (rdata !== 4'h0) $display("FAIL reset_rdata: got %h want 0", rdata); else n_pass++;
      end
      commit();
      for (int k = 0; k < 9; k++) begin
         drive(0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
         n_total++;
         if (ready !== (k == 8)) $display("FAIL reset_sweep_ready cycle %0d: got %b want %b", k, ready, (k == 8));
         else n_pass++;
         commit();
      end
      for (int i = 0; i < 9; i++) begin
         drive(0, 0, (i < 8) ? 2'b01 : 2'b00, 2'b00, 3'(i), 0, 0, 0);
         n_total++; if (gnt !== e_gnt) $display("FAIL reset_read gnt: got %b want %b", gnt, e_gnt); else n_pass++;
         if (i > 0) begin
            n_total++;
            if (rvalid !== 2'b01 || rdata !== 4'h0)
               $display("FAIL reset_read addr %0d: got rvalid %b rdata %h want 01 0", i - 1, rvalid, rdata);
            else n_pass++;
         end
         commit();
      end
   endtask

   task automatic test_single();
      drive(0, 0, 2'b01, 2'b01, 3'd3, 4'hD, 0, 0);
      n_total++; if (gnt !== 2'b01) $display("FAIL single_wr gnt: got %b want 01", gnt); else n_pass++;
      commit();
      drive(0, 0, 2'b01, 2'b00, 3'd3, 4'h0, 0, 0);
      n_total++; if (gnt !== 2'b01) $display("FAIL single_rd gnt: got %b want 01", gnt); else n_pass++;
      n_total++; if (rvalid !== 2'b00) $display("FAIL single_wr no_rvalid: got %b want 00", rvalid); else n_pass++;
      commit();
      drive(0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
      n_total++; if (rvalid !== 2'b01) $display("FAIL single_rd rvalid: got %b want 01", rvalid); else n_pass++;
      n_total++; if (rdata !== 4'hD) $display("FAIL single_rd rdata: got %h want d", rdata); else n_pass++;
      commit();
      drive(0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
      n_total++; if (rvalid !== 2'b00 || rdata !== 4'hD) $display("FAIL single_hold: got %b %h want 00 d", rvalid, rdata); else n_pass++;
      commit();
   endtask

   task automatic test_contention();
      logic [2:0] ad0, ad1;
      logic [1:0] prev;
      ad0 = 3'($urandom_range(7)); ad1 = 3'($urandom_range(7));
      prev = 2'b00;
      for (int k = 0; k < 11; k++) begin
         drive(0, 0, (k < 10) ? 2'b11 : 2'b00, 2'b00, ad0, 0, ad1, 0);
         n_total++; if (gnt !== e_gnt) $display("FAIL contention gnt: got %b want %b", gnt, e_gnt); else n_pass++;
         n_total++; if (rvalid !== e_rvalid) $display("FAIL contention rvalid: got %b want %b", rvalid, e_rvalid); else n_pass++;
         n_total++; if (rdata !== e_rdata) $display("FAIL contention rdata: got %h want %h", rdata, e_rdata); else n_pass++;
         if (k > 0 && k < 10) begin
            n_total++;
            if (gnt !== {prev[0], prev[1]}) $display("FAIL contention alternate: got %b want %b", gnt, {prev[0], prev[1]});
            else n_pass++;
         end
         if (k > 0) begin
            n_total++; if (rvalid !== prev) $display("FAIL contention follow: got %b want %b", rvalid, prev); else n_pass++;
         end
         commit();
         prev = gnt;
         if (gnt[0]) ad0 = 3'($urandom_range(7));
         if (gnt[1]) ad1 = 3'($urandom_range(7));
      end
   endtask

   task automatic test_back_to_back();
      drive(0, 0, 2'b10, 2'b10, 0, 0, 3'd7, 4'h5);
      n_total++; if (gnt !== 2'b10) $display("FAIL b2b_wr gnt: got %b want 10", gnt); else n_pass++;
      commit();
      drive(0, 0, 2'b01, 2'b00, 3'd7, 0, 0, 0);
      n_total++; if (gnt !== 2'b01) $display("FAIL b2b_rd gnt: got %b want 01", gnt); else n_pass++;
      commit();
      drive(0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
      n_total++; if (rvalid !== 2'b01 || rdata !== 4'h5) $display("FAIL b2b_rdata: got %b %h want 01 5", rvalid, rdata); else n_pass++;
      commit();
   endtask

   task automatic test_clear();
      drive(0, 0, 2'b01, 2'b01, 3'd6, 4'hF, 0, 0); commit();
      drive(0, 1, 2'b01, 2'b00, 3'd6, 0, 0, 0);
      n_total++; if (gnt !== 2'b00) $display("FAIL clear_wins gnt: got %b want 00", gnt); else n_pass++;
      commit();
      for (int k = 0; k < 9; k++) begin
         drive(0, k[0], (k < 8) ? 2'b11 : 2'b01, 2'b00, 3'd6, 0, 3'd6, 0);
         n_total++; if (ready !== (k == 8)) $display("FAIL clear_ready cycle %0d: got %b want %b", k, ready, (k == 8)); else n_pass++;
         n_total++; if (gnt !== e_gnt) $display("FAIL clear_gnt cycle %0d: got %b want %b", k, gnt, e_gnt); else n_pass++;
         commit();
      end
      drive(0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
      n_total++; if (rvalid !== 2'b01 || rdata !== 4'h0) $display("FAIL clear_addr6: got %b %h want 01 0", rvalid, rdata); else n_pass++;
      commit();
   endtask

   task automatic test_reset_mid();
      drive(0, 0, 2'b01, 2'b01, 3'd0, 4'hA, 0, 0); commit();
      drive(0, 0, 2'b10, 2'b10, 0, 0, 3'd5, 4'hB); commit();
      drive(1, 0, 2'b00, 2'b00, 0, 0, 0, 0); commit();
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 2'b00, 2'b00, 0, 0, 0, 0); commit();
      end
      drive(1, 0, 2'b00, 2'b00, 0, 0, 0, 0); commit();
      for (int k = 0; k < 9; k++) begin
         drive(0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
         n_total++; if (ready !== (k == 8)) $display("FAIL midclr_ready cycle %0d: got %b want %b", k, ready, (k == 8)); else n_pass++;
         commit();
      end
      drive(0, 0, 2'b11, 2'b00, 3'd0, 0, 3'd5, 0); commit();
      drive(0, 0, 2'b10, 2'b00, 3'd0, 0, 3'd5, 0);
      n_total++; if (rvalid !== 2'b01 || rdata !== 4'h0) $display("FAIL midclr_addr0: got %b %h want 01 0", rvalid, rdata); else n_pass++;
      commit();
      drive(0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
      n_total++; if (rvalid !== 2'b10 || rdata !== 4'h0) $display("FAIL midclr_addr5: got %b %h want 10 0", rvalid, rdata); else n_pass++;
      commit();
      // Reset arriving together with a read request: no response may follow.
      drive(1, 0, 2'b01, 2'b00, 3'd3, 0, 0, 0); commit();
      for (int k = 0; k < 9; k++) begin
         drive(0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
         n_total++; if (rvalid !== 2'b00) $display("FAIL midrd_rvalid cycle %0d: got %b want 00", k, rvalid); else n_pass++;
         commit();
      end
   endtask

   task automatic test_random();
      logic [1:0] p_req, p_we;
      logic [2:0] p_a [2];
      logic [3:0] p_d [2];
      p_req = 2'b00; p_we = 2'b00;
      p_a[0] = 0; p_a[1] = 0; p_d[0] = 0; p_d[1] = 0;
      for (int k = 0; k < 400; k++) begin
         for (int n = 0; n < 2; n++) begin
            if (!p_req[n] && $urandom_range(1) == 1) begin
               p_req[n] = 1'b1;
               p_we[n]  = 1'($urandom_range(1));
               p_a[n]   = 3'($urandom_range(7));
               p_d[n]   = 4'($urandom_range(15));
            end
         end
         drive(($urandom_range(149) == 0), ($urandom_range(39) == 0), p_req, p_we, p_a[0], p_d[0], p_a[1], p_d[1]);
         n_total++; if (gnt !== e_gnt) $display("FAIL random gnt: got %b want %b", gnt, e_gnt); else n_pass++;
         n_total++; if (ready !== (m_clear_left == 0)) $display("FAIL random ready: got %b want %b", ready, (m_clear_left == 0)); else n_pass++;
         n_total++; if (rvalid !== e_rvalid) $display("FAIL random rvalid: got %b want %b", rvalid, e_rvalid); else n_pass++;
         n_total++; if (rdata !== e_rdata) $display("FAIL random rdata: got %h want %h", rdata, e_rdata); else n_pass++;
         commit();
         p_req = p_req & ~e_gnt;
      end
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; req = 2'b00; we = 2'b00;
      a0 = 3'd0; a1 = 3'd0; d0 = 4'h0; d1 = 4'h0;
      test_reset();
      test_single();
      test_contention();
      test_back_to_back();
      test_clear();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
